pc_ctrl: RTL and testbench

Program-counter source sequencer for the 8-bit pipelined processor. It drives the select inputs of the next-PC mux (`pc_src`, `pc_in_sel`) and the PC register write enable. It sequences the boot jump to the reset vector, taken branches, RET/RTI stack returns and interrupt entry, and flushes the front end whenever fetch is redirected.

---
 rtl/pc_ctrl_pkg.sv | 45 ++++
 rtl/pc_ctrl_irq_sync.sv | 43 ++++
 rtl/pc_ctrl.sv | 156 +++++++++++++++
 tb/tb_pc_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the PC source sequencer
//
// Contents:
//   PTR_W      width of the pc_in_sel select code
//   state_t    sequencer states (BOOT, RUN, INT_PUSH, RET_WAIT)
//   SEL_*      pc_in_sel codes for the next-PC mux
//   ctrl_t     bundle of the mux/pipeline control outputs
package pc_ctrl_pkg;

    localparam int PTR_W = 2;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_INT_PUSH = 2'b10,
        ST_RET_WAIT = 2'b11
    } state_t;

    localparam logic [PTR_W-1:0] SEL_INT    = 2'b00;
    localparam logic [PTR_W-1:0] SEL_STACK  = 2'b01;
    localparam logic [PTR_W-1:0] SEL_BRANCH = 2'b10;
    localparam logic [PTR_W-1:0] SEL_RESET  = 2'b11;

    typedef struct packed {
        logic             pc_src;
        logic [PTR_W-1:0] pc_in_sel;
        logic             pc_write;
        logic             flush;
        logic             push_pc;
        logic             int_ack;
    } ctrl_t;

    // Every redirect of the next-PC mux kills the front end.
    function automatic ctrl_t redirect(input logic [PTR_W-1:0] sel);
        ctrl_t c;
        c.pc_src    = 1'b1;
        c.pc_in_sel = sel;
        c.pc_write  = 1'b1;
        c.flush     = 1'b1;
        c.push_pc   = 1'b0;
        c.int_ack   = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pc_ctrl_irq_sync.sv
// rtl/pc_ctrl_irq_sync.sv - interrupt request synchronizer with optional edge detect
//
// Ports:
//   clk                 in   rising-edge clock
//   rst_n               in   asynchronous active-low reset
//   irq                 in   asynchronous external interrupt request
//   irq_pulse_or_level  out  synchronized level, or a one-cycle rising-edge
//                            pulse when PC_CTRL_IRQ_EDGE_EN is defined
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic irq_pulse_or_level
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], irq};
        end
    end

`ifdef PC_CTRL_IRQ_EDGE_EN
    // One pulse per rising edge, so a held-high request is taken only once.
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync_q[1];
        end
    end

    assign irq_pulse_or_level = sync_q[1] & ~prev_q;
`else
    assign irq_pulse_or_level = sync_q[1];
`endif

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program-counter source sequencer for the pipelined core
//
// Optional feature macro: PC_CTRL_IRQ_EDGE_EN (edge-triggered interrupt request).
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   stall         in   hazard stall, freezes the PC in RUN
//   branch_taken  in   resolved taken branch/jump from EX
//   is_ret        in   RET in MEM, requests a stack pop
//   is_rti        in   RTI in MEM, RET plus interrupt re-enable
//   pop_valid     in   popped return address present on the stack bus
//   push_done     in   datapath has pushed the return PC
//   irq           in   asynchronous external interrupt request
//   pc_src        out  0: pc_plus_1, 1: select by pc_in_sel
//   pc_in_sel     out  00 interrupt, 01 stack, 10 branch, 11 reset vector
//   pc_write      out  PC register load enable
//   flush         out  kill IF/ID contents
//   push_pc       out  request push of the current PC for interrupt entry
//   int_ack       out  one-cycle interrupt acknowledge
//   ie            out  interrupt-enable flag
module pc_ctrl
    import pc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             is_ret,
    input  logic             is_rti,
    input  logic             pop_valid,
    input  logic             push_done,
    input  logic             irq,
    output logic             pc_src,
    output logic [PTR_W-1:0] pc_in_sel,
    output logic             pc_write,
    output logic             flush,
    output logic             push_pc,
    output logic             int_ack,
    output logic             ie
);

    state_t state_q;
    state_t state_d;
    logic   ie_q;
    logic   pending_q;
    logic   rti_q;
    logic   irq_req;
    logic   ie_set;
    logic   ie_clr;
    logic   latch_rti;
    ctrl_t  ctrl;

    irq_sync u_irq_sync (
        .clk                (clk),
        .rst_n              (rst_n),
        .irq                (irq),
        .irq_pulse_or_level (irq_req)
    );

    always_comb begin
        state_d        = state_q;
        ctrl.pc_src    = 1'b0;
        ctrl.pc_in_sel = SEL_INT;
        ctrl.pc_write  = 1'b0;
        ctrl.flush     = 1'b0;
        ctrl.push_pc   = 1'b0;
        ctrl.int_ack   = 1'b0;
        ie_set         = 1'b0;
        ie_clr         = 1'b0;
        latch_rti      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                ctrl    = redirect(SEL_RESET);
                ie_set  = 1'b1;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (is_ret || is_rti) begin
                    // Returns outrank a same-cycle branch; the branch is dropped.
                    ctrl.flush = 1'b1;
                    latch_rti  = 1'b1;
                    state_d    = ST_RET_WAIT;
                end else if (branch_taken && !stall) begin
                    ctrl = redirect(SEL_BRANCH);
                end else if (pending_q && ie_q && !stall) begin
                    ctrl.flush   = 1'b1;
                    ctrl.push_pc = 1'b1;
                    state_d      = ST_INT_PUSH;
                end else begin
                    ctrl.pc_write = ~stall;
                end
            end

            ST_INT_PUSH: begin
                // stall is deliberately ignored while the push is in flight.
                if (push_done) begin
                    ctrl         = redirect(SEL_INT);
                    ctrl.int_ack = 1'b1;
                    ie_clr       = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    ctrl.flush   = 1'b1;
                    ctrl.push_pc = 1'b1;
                end
            end

            ST_RET_WAIT: begin
                if (pop_valid) begin
                    ctrl    = redirect(SEL_STACK);
                    ie_set  = rti_q;
                    state_d = ST_RUN;
                end else begin
                    ctrl.flush = 1'b1;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            ie_q      <= 1'b0;
            pending_q <= 1'b0;
            rti_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ie_clr) begin
                ie_q <= 1'b0;
            end else if (ie_set) begin
                ie_q <= 1'b1;
            end
            // A new request in the acknowledge cycle is kept, not lost.
            pending_q <= (pending_q & ~ctrl.int_ack) | irq_req;
            if (latch_rti) begin
                rti_q <= is_rti;
            end
        end
    end

    // BOOT decodes a PC load, but nothing may load while reset is held.
    assign pc_write  = ctrl.pc_write & rst_n;
    assign pc_src    = ctrl.pc_src;
    assign pc_in_sel = ctrl.pc_in_sel;
    assign flush     = ctrl.flush;
    assign push_pc   = ctrl.push_pc;
    assign int_ack   = ctrl.int_ack;
    assign ie        = ie_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - directed self-checking bench for pc_ctrl
module tb_pc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       branch_taken;
    logic       is_ret;
    logic       is_rti;
    logic       pop_valid;
    logic       push_done;
    logic       irq;
    logic       pc_src;
    logic [1:0] pc_in_sel;
    logic       pc_write;
    logic       flush;
    logic       push_pc;
    logic       int_ack;
    logic       ie;

    int checks = 0;
    int errors = 0;

    pc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .is_ret       (is_ret),
        .is_rti       (is_rti),
        .pop_valid    (pop_valid),
        .push_done    (push_done),
        .irq          (irq),
        .pc_src       (pc_src),
        .pc_in_sel    (pc_in_sel),
        .pc_write     (pc_write),
        .flush        (flush),
        .push_pc      (push_pc),
        .int_ack      (int_ack),
        .ie           (ie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {pc_src, pc_in_sel[1:0], pc_write, flush, push_pc, int_ack, ie}
    localparam logic [7:0] V_RESET    = 8'b1_11_0_1_0_0_0;
    localparam logic [7:0] V_BOOT     = 8'b1_11_1_1_0_0_0;
    localparam logic [7:0] V_IDLE_IE  = 8'b0_00_1_0_0_0_1;
    localparam logic [7:0] V_IDLE_NIE = 8'b0_00_1_0_0_0_0;
    localparam logic [7:0] V_STALL_IE = 8'b0_00_0_0_0_0_1;
    localparam logic [7:0] V_BRANCH   = 8'b1_10_1_1_0_0_1;
    localparam logic [7:0] V_RWAIT_IE = 8'b0_00_0_1_0_0_1;
    localparam logic [7:0] V_RWAIT_NI = 8'b0_00_0_1_0_0_0;
    localparam logic [7:0] V_POP_IE   = 8'b1_01_1_1_0_0_1;
    localparam logic [7:0] V_POP_NIE  = 8'b1_01_1_1_0_0_0;
    localparam logic [7:0] V_PUSH     = 8'b0_00_0_1_1_0_1;
    localparam logic [7:0] V_ACK      = 8'b1_00_1_1_0_1_1;

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {pc_src, pc_in_sel, pc_write, flush, push_pc, int_ack, ie};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check(input string tag, input logic [7:0] exp);
        #1;
        check(tag, exp);
    endtask

    initial begin
        rst_n        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        is_ret       = 1'b0;
        is_rti       = 1'b0;
        pop_valid    = 1'b0;
        push_done    = 1'b0;
        irq          = 1'b0;

        #3;
        check("reset_values", V_RESET);
        #5;
        rst_n = 1'b1;
        settle_check("boot_cycle", V_BOOT);
        step();
        check("run_idle", V_IDLE_IE);

        // Branch without and with stall.
        branch_taken = 1'b1;
        settle_check("branch_taken", V_BRANCH);
        step();
        stall = 1'b1;
        settle_check("branch_stalled_0", V_STALL_IE);
        step();
        settle_check("branch_stalled_1", V_STALL_IE);
        step();
        stall = 1'b0;
        settle_check("branch_after_stall", V_BRANCH);
        step();
        branch_taken = 1'b0;

        // RET with pop_valid three cycles later; stall ignored while waiting.
        is_ret = 1'b1;
        settle_check("ret_entry", V_RWAIT_IE);
        step();
        is_ret = 1'b0;
        settle_check("ret_wait_1", V_RWAIT_IE);
        step();
        stall = 1'b1;
        settle_check("ret_wait_2_stall", V_RWAIT_IE);
        step();
        pop_valid = 1'b1;
        settle_check("ret_pop_load", V_POP_IE);
        step();
        pop_valid = 1'b0;
        stall     = 1'b0;
        settle_check("ret_back_to_run", V_IDLE_IE);

        // RET and branch together: RET wins, no branch load.
        is_ret       = 1'b1;
        branch_taken = 1'b1;
        settle_check("ret_and_branch", V_RWAIT_IE);
        step();
        is_ret       = 1'b0;
        branch_taken = 1'b0;
        settle_check("ret_and_branch_wait", V_RWAIT_IE);
        step();
        pop_valid = 1'b1;
        settle_check("ret_and_branch_pop", V_POP_IE);
        step();
        pop_valid = 1'b0;

        // Interrupt: one-cycle irq, two synchronizer edges, then pending.
        irq = 1'b1;
        step();
        irq = 1'b0;
        settle_check("irq_sync_0", V_IDLE_IE);
        step();
        settle_check("irq_sync_1", V_IDLE_IE);
        step();
        settle_check("irq_push_request", V_PUSH);
        step();
        stall = 1'b1;
        settle_check("irq_push_hold", V_PUSH);
        step();
        push_done = 1'b1;
        settle_check("irq_ack", V_ACK);
        step();
        push_done = 1'b0;
        stall     = 1'b0;
        settle_check("irq_isr_ie_clear", V_IDLE_NIE);

        // Second request while ie = 0 stays pending until RTI completes.
        irq = 1'b1;
        step();
        irq = 1'b0;
        step();
        step();
        settle_check("irq2_masked_0", V_IDLE_NIE);
        step();
        settle_check("irq2_masked_1", V_IDLE_NIE);
        is_rti = 1'b1;
        settle_check("rti_entry", V_RWAIT_NI);
        step();
        is_rti    = 1'b0;
        pop_valid = 1'b1;
        settle_check("rti_pop_load", V_POP_NIE);
        step();
        pop_valid = 1'b0;
        settle_check("irq2_taken_after_rti", V_PUSH);
        step();
        push_done = 1'b1;
        settle_check("irq2_ack", V_ACK);
        step();
        push_done = 1'b0;
        settle_check("irq2_isr", V_IDLE_NIE);

        // Re-enable with an RTI, then reset in the middle of INT_PUSH.
        is_rti = 1'b1;
        step();
        is_rti    = 1'b0;
        pop_valid = 1'b1;
        step();
        pop_valid = 1'b0;
        settle_check("rti2_ie_set", V_IDLE_IE);
        irq = 1'b1;
        step();
        irq = 1'b0;
        step();
        step();
        settle_check("irq3_push_request", V_PUSH);
        step();
        settle_check("irq3_in_push", V_PUSH);
        rst_n     = 1'b0;
        push_done = 1'b1;
        settle_check("reset_mid_push", V_RESET);
        step();
        settle_check("reset_held", V_RESET);
        push_done = 1'b0;
        rst_n     = 1'b1;
        settle_check("boot_after_reset", V_BOOT);
        step();
        settle_check("run_after_reset", V_IDLE_IE);
        for (int i = 0; i < 4; i++) begin
            step();
            settle_check("no_pending_after_reset", V_IDLE_IE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
